// File: rtl/enc_pkg.sv
// Shared types and constants for the 4-to-2 queued encoder.
package enc_pkg;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned CODE_W = $clog2(N_REQ);

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [N_REQ-1:0]  req_t;

    // Output register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } out_state_e;

    // One-hot mask for a binary index
    function automatic req_t onehot(input code_t idx);
        return req_t'(1) << idx;
    endfunction

endpackage

// File: rtl/enc4to2_queued_if.sv
// Event/code bus between sources, the encoder and its consumer.
interface enc4to2_queued_if;

    enc_pkg::req_t  req;
    enc_pkg::code_t code;
    logic           valid;
    logic           ready;
    enc_pkg::req_t  pending;
    logic           drop;

    // Encoder side: takes events and ready, presents codes and status
    modport master (
        input  req,
        input  ready,
        output code,
        output valid,
        output pending,
        output drop
    );

    // Consumer/source side
    modport slave (
        output req,
        output ready,
        input  code,
        input  valid,
        input  pending,
        input  drop
    );

endinterface

// File: rtl/prio_enc4.sv
// Combinational priority encoder, highest set index wins.
module prio_enc4 import enc_pkg::*; (
    input  req_t  req_i,
    output code_t code_o,
    output logic  any_o
);

    // Scan from the top line down
    always_comb begin
        code_o = '0;
        any_o  = |req_i;
        if (req_i[3])      code_o = CODE_W'(3);
        else if (req_i[2]) code_o = CODE_W'(2);
        else if (req_i[1]) code_o = CODE_W'(1);
        else               code_o = CODE_W'(0);
    end

endmodule

// File: rtl/enc4to2_queued.sv
// Sticky event capture with a registered valid/ready code output.
module enc4to2_queued import enc_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    enc4to2_queued_if.master  bus
);

    out_state_e state_q, state_d;
    code_t      code_q, code_d;
    req_t       pending_q, pending_d;
    logic       drop_q, drop_d;

    code_t      sel_code;
    logic       sel_any;
    logic       load;
    req_t       clr;

    // Selection looks only at registered pending bits
    prio_enc4 u_prio (
        .req_i  (pending_q),
        .code_o (sel_code),
        .any_o  (sel_any)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            code_q    <= '0;
            pending_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    // Load decision, pending update (set beats clear) and drop detect
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        load    = 1'b0;
        clr     = '0;

        case (state_q)
            EMPTY: begin
                if (sel_any) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.ready) begin
                    if (sel_any) load    = 1'b1;
                    else         state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (load) begin
            clr    = onehot(sel_code);
            code_d = sel_code;
        end

        pending_d = (pending_q & ~clr) | bus.req;
        drop_d    = |(bus.req & pending_q & ~clr);
    end

    assign bus.code    = code_q;
    assign bus.valid   = (state_q == HOLD);
    assign bus.pending = pending_q;
    assign bus.drop    = drop_q;

endmodule

// File: tb/tb_enc4to2_queued.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-level model.
module tb_enc4to2_queued;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    enc4to2_queued_if bus ();

    enc4to2_queued dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a set of waiting events plus one output slot
    logic [3:0] m_pend;
    logic       m_valid;
    logic [1:0] m_code;
    logic       m_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  = 4'b0000;
            m_valid = 1'b0;
            m_code  = 2'b00;
            m_drop  = 1'b0;
        end else begin
            int         top;
            logic [3:0] taken;
            logic [3:0] nxt;
            logic       dr;
            top = -1;
            for (int i = 3; i >= 0; i--)
                if (m_pend[i] && top < 0) top = i;
            taken = 4'b0000;
            if (top >= 0 && (!m_valid || bus.ready)) begin
                taken[top] = 1'b1;
                m_code     = 2'(top);
                m_valid    = 1'b1;
            end else if (m_valid && bus.ready) begin
                m_valid = 1'b0;
            end
            nxt = 4'b0000;
            dr  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (bus.req[i] && m_pend[i] && !taken[i]) dr = 1'b1;
                nxt[i] = (m_pend[i] && !taken[i]) || bus.req[i];
            end
            m_pend = nxt;
            m_drop = dr;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", int'(bus.valid), int'(m_valid));
            if (m_valid) chk("code", int'(bus.code), int'(m_code));
            chk("pending", int'(bus.pending), int'(m_pend));
            chk("drop", int'(bus.drop), int'(m_drop));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req   = 4'b1111;
        bus.ready = 1'b0;

        // Reset with all lines active
        repeat (3) step();
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_code", int'(bus.code), 0);
        chk("rst_pending", int'(bus.pending), 0);
        rst_n = 1'b1;
        step();
        chk("rel_pending", int'(bus.pending), 4'hf);
        bus.req = 4'b0000;
        step();
        chk("rel_valid", int'(bus.valid), 1);
        chk("rel_code", int'(bus.code), 3);
        bus.ready = 1'b1;
        step(); chk("rel_c2", int'(bus.code), 2);
        step(); chk("rel_c1", int'(bus.code), 1);
        step(); chk("rel_c0", int'(bus.code), 0);
        step(); chk("rel_empty", int'(bus.valid), 0);

        // Single event
        bus.req = 4'b0100;
        step();
        bus.req = 4'b0000;
        chk("one_pend", int'(bus.pending), 4'b0100);
        chk("one_notyet", int'(bus.valid), 0);
        step();
        chk("one_valid", int'(bus.valid), 1);
        chk("one_code", int'(bus.code), 2);
        chk("one_pclr", int'(bus.pending), 0);
        step();
        chk("one_gone", int'(bus.valid), 0);

        // Multi-event ordering
        bus.req = 4'b1011;
        step();
        bus.req = 4'b0000;
        step(); chk("ord_c3", int'(bus.code), 3);
        step(); chk("ord_c1", int'(bus.code), 1);
        step(); chk("ord_c0", int'(bus.code), 0);
        chk("ord_valid", int'(bus.valid), 1);
        step(); chk("ord_empty", int'(bus.valid), 0);

        // Backpressure
        bus.ready = 1'b0;
        bus.req   = 4'b0011;
        step();
        bus.req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", int'(bus.valid), 1);
            chk("bp_code", int'(bus.code), 1);
            chk("bp_pend", int'(bus.pending), 4'b0001);
        end
        bus.ready = 1'b1;
        step(); chk("bp_c0", int'(bus.code), 0);
        step(); chk("bp_empty", int'(bus.valid), 0);

        // Drop on a line already pending
        bus.ready = 1'b0;
        bus.req   = 4'b1000;
        step();
        bus.req = 4'b0000;
        step();
        chk("drp_hold", int'(bus.code), 3);
        bus.req = 4'b0001;
        step();
        chk("drp_nodrop", int'(bus.drop), 0);
        step();
        bus.req = 4'b0000;
        chk("drp_pulse", int'(bus.drop), 1);
        chk("drp_pend", int'(bus.pending), 4'b0001);
        step();
        chk("drp_once", int'(bus.drop), 0);
        bus.ready = 1'b1;
        step(); chk("drp_c0", int'(bus.code), 0);
        step(); chk("drp_single", int'(bus.valid), 0);
        step(); chk("drp_still", int'(bus.valid), 0);

        // Async reset between edges
        bus.ready = 1'b0;
        bus.req   = 4'b1100;
        step();
        bus.req = 4'b0000;
        step();
        chk("ar_pre", int'(bus.valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", int'(bus.valid), 0);
        chk("ar_pend", int'(bus.pending), 0);
        chk("ar_code", int'(bus.code), 0);
        step();
        rst_n = 1'b1;

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.req   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            bus.ready = ($urandom_range(0, 3) != 0);
            if (cyc == 1500) begin
                #2;
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        bus.req   = 4'b0000;
        bus.ready = 1'b1;
        repeat (8) step();
        chk("drain_empty", int'(bus.valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enc4to2_queued.md
# enc4to2_queued

Sequential 4-to-2 encoder: the encoding counterpart of the team's 2-to-4 `decoder`. It captures event pulses on four one-hot request lines into sticky pending bits. It emits the index of the highest-priority pending event as a 2-bit code through a valid/ready handshake, one code per accepted transfer. It sits between event sources (line-select logic, interrupt-style strobes) and any consumer that needs binary indices, and its output feeds `decoder` directly when regenerating one-hot selects.

## Interface
- `N`, 4: number of request lines; fixed at 4 for this block, kept as a parameter for the package constant.
- `W`, 2: code width, `$clog2(N)`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  event pulses; bit i high in a cycle = one event on line i.
- `code`  out  W  binary index of the presented event; `req[3]` -> 2'b11, ..., `req[0]` -> 2'b00.
- `valid`  out  1  `code` holds an unaccepted event.
- `ready`  in  1  consumer accepts `code` when `valid && ready` at a rising edge.
- `pending`  out  N  sticky pending bits, registered, for debug/status.
- `drop`  out  1  one-cycle pulse: an event arrived on a line already pending; that event is lost.

## Operation
- Reset (async assert, sync deassert by the environment): `pending`=0, `code`=2'b00, `valid`=0, `drop`=0.
- Capture: each edge, `pending <= (pending & ~clr) | req`, where `clr` is the one-hot of the index loaded into the output register this edge.
- Priority: fixed, highest index wins (3 > 2 > 1 > 0). Selection is combinational from registered `pending` only. `req` in the current cycle is not visible to selection.
- Output register states: EMPTY (`valid`=0) and HOLD (`valid`=1).
  - EMPTY: if any `pending` bit is set, load the selected index, clear that pending bit, and go to HOLD. Otherwise stay.
  - HOLD, no `ready`: `code` and `valid` are stable. No pending bit is cleared.
  - HOLD with `ready`: if any `pending` is set, load the next selected index the same edge (back-to-back, no bubble). Otherwise go to EMPTY.
- Simultaneous set/clear on the same bit: set wins. A new `req[i]` on the edge where i is loaded re-arms `pending[i]` as a new event.
- Re-request of a line whose event is currently in the output register (not pending) is a new event, not a drop.
- `drop` = `|(req & pending & ~clr)`, registered. It pulses the cycle after the offending edge.
- Starvation of low lines under constant high-line traffic is accepted behaviour.
- Reset mid-transfer: everything returns to the reset values immediately. Pending events are discarded.

## Timing
- Latency: `req[i]` high in cycle k -> `pending[i]`=1 in cycle k+1 -> `valid`=1 with `code`=i in cycle k+2 (from EMPTY).
- Throughput: one code per cycle while `ready`=1 and events are pending.
- `code` and `valid` are registered. There is no combinational path from `req` or `ready` to any output.
- `ready` may be high while `valid`=0; it has no effect then.

## Structure
- Shared package `enc_pkg`: `N_REQ`=4, `CODE_W`=2, `typedef logic [CODE_W-1:0] code_t`, `typedef logic [N_REQ-1:0] req_t`.
- One natural sub-module, `prio_enc4`: combinational highest-index-first priority encoder. It takes `req_t`, returns `code_t` plus `any`, and is reused wherever priority encoding is needed.

## Test plan
- Reset: hold `rst_n`=0 with `req`=4'b1111 -> `valid`=0, `code`=00, `pending`=0. Release; 2 cycles later `valid`=1, `code`=11.
- Single event, `ready`=1: `req`=4'b0100 for one cycle -> `valid`=1, `code`=10 two cycles later for exactly one cycle. `pending` then returns to 0.
- Multi-event ordering: `req`=4'b1011 for one cycle, `ready`=1 -> `code` sequence 11, 01, 00 on consecutive cycles, then `valid`=0.
- Backpressure: `req`=4'b0011, `ready`=0 for 5 cycles -> `code`=01 stable with `valid`=1. `pending`=4'b0001. Raise `ready` -> 00 next, then empty.
- Drop: `req`=4'b0001 on two consecutive cycles with `ready`=0 and output holding 11 -> one `drop` pulse, and only one 00 is delivered.
- Async reset mid-stream: assert `rst_n`=0 between clock edges while `valid`=1 -> `valid`=0 and `pending`=0 immediately, without waiting for an edge.
